noc_output_arbiter: RTL and testbench
=====================================

Name: noc_output_arbiter

Overview:
- Per-output-port arbiter for the NoC router. It shares one output link between NUM_REQ input ports, for example N/S/E/W/Proc.
- Wormhole switching: once a header flit wins, the port stays locked to that requester until the packet's last flit has been sent.
- An integrated credit counter tracks free slots in the downstream NIB under valid/yummy flow control. A flit is only granted when a credit is available.

Parameters:
- NUM_REQ, 5, number of requesting input ports.
- REQ_BITS, 3, width of requester index; must satisfy 2^REQ_BITS >= NUM_REQ.
- BUFFER_SIZE, 4, depth of the downstream NIB; this is the initial credit count.
- BUFFER_BITS, 3, width of the credit counter; must hold the value BUFFER_SIZE.
- LEN_BITS, 8, width of the payload-length field carried in the header flit.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous reset, active-high.
- req  input  NUM_REQ  per-requester flit-valid; bit i means requester i has a flit ready.
- req_len  input  NUM_REQ*LEN_BITS  payload length for requester i, in bits [i*LEN_BITS +: LEN_BITS]. Sampled only when requester i wins in IDLE.
- yummy_in  input  1  credit return from the downstream NIB; one slot is freed per cycle it is high.
- grant  output  NUM_REQ  one-hot, combinational; the granted requester's flit is transferred this cycle.
- valid_out  output  1  equals the OR of all grant bits; drives the output link's valid signal.
- locked  output  1  registered; high while the FSM is in BUSY.
- owner  output  REQ_BITS  registered; index of the locked requester; 0 when idle.
- credit_count  output  BUFFER_BITS  registered credit count.
- credit_err  output  1  sticky registered flag for credit overflow.

Behaviour:
- Reset (synchronous, high at posedge clk):
  - state goes to IDLE; rr_ptr = 0; remaining = 0; owner = 0.
  - credit_count = BUFFER_SIZE; credit_err = 0.
  - grant and valid_out are 0 while reset is high.
  - Reset mid-packet abandons the packet; there is no recovery of credits in flight.
- Credit availability: cred_ok = (credit_count != 0).
- Credit counter update each cycle:
  - valid_out high and yummy_in low: decrement by 1.
  - yummy_in high and valid_out low: increment by 1.
  - Both high: hold.
  - Neither high: hold.
  - Increment at credit_count == BUFFER_SIZE: hold the count and set credit_err. credit_err stays set until reset.
  - Decrement at 0 cannot occur, because grant requires cred_ok.
- IDLE state:
  - If cred_ok is high and req is non-zero, grant the first set req bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - The winner's header flit is sent in the same cycle.
  - If len is 0: stay in IDLE; rr_ptr = (winner+1) mod NUM_REQ.
  - Otherwise: go to BUSY; owner = winner; remaining = len.
  - No request, or no credit: grant = 0; state and rr_ptr are unchanged.
- BUSY state:
  - grant[owner] = req[owner] & cred_ok. All other requesters are ignored.
  - Each granted cycle decrements remaining.
  - The grant in the cycle where remaining == 1 sends the tail flit. The next state is IDLE, with rr_ptr = (owner+1) mod NUM_REQ and owner cleared to 0.
  - If the owner deasserts req, or no credit is available: send a bubble (no grant), hold the lock and hold remaining.
- Latency:
  - A grant is combinational from req and registered state; there are zero cycles from request to grant.
  - A returned credit becomes usable in the cycle after yummy_in is sampled.
- Back-to-back packets: after the tail flit, IDLE arbitration happens in the very next cycle, with no dead cycle.
- Wrap-around: rr_ptr increments modulo NUM_REQ, so winner NUM_REQ-1 sets rr_ptr to 0.

Test Plan:
- Reset, then req=5'b00001 with len=0, and no yummy for 4 cycles: 4 grants, credit_count goes 4→0. Cycle 5: grant=0, valid_out=0.
- Continue from the previous case with yummy_in pulsed for 1 cycle: credit_count becomes 1 and one further grant issues the cycle after. yummy_in and valid_out high in the same cycle: count unchanged.
- req=5'b11111, all len=0, yummy_in tied high: grants rotate 0,1,2,3,4,0 on consecutive cycles.
- Requester 2 header with len=3 and requester 0 also requesting, credits ample: grant[2] for 4 consecutive cycles with locked=1 and owner=2. Then grant[0] on cycle 5; rr_ptr has moved to 3.
- Locked to owner 1 with remaining=2, owner drops req for 3 cycles: grant=0 and locked=1 throughout. When req is reasserted, 2 more grants are issued, then unlock.
- yummy_in pulsed at credit_count=4: count stays at 4, credit_err=1. credit_err stays 1 until reset is asserted; reset asserted mid-packet gives locked=0, credit_count=4, credit_err=0 on the next cycle.

Source files
------------

// File: rtl/noc_output_arbiter.sv
// Output-port arbiter for a wormhole NoC router.
// Round-robin arbitration happens on header flits. The winner then holds the
// link until its tail flit has gone. Flits are only sent while the downstream
// NIB has a free slot, tracked by a valid/yummy credit counter.
module noc_output_arbiter #(
    parameter int NUM_REQ     = 5,
    parameter int REQ_BITS    = 3,
    parameter int BUFFER_SIZE = 4,
    parameter int BUFFER_BITS = 3,
    parameter int LEN_BITS    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*LEN_BITS-1:0]  req_len,
    input  logic                         yummy_in,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         valid_out,
    output logic                         locked,
    output logic [REQ_BITS-1:0]          owner,
    output logic [BUFFER_BITS-1:0]       credit_count,
    output logic                         credit_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state, state_n;
    logic [REQ_BITS-1:0]   rr_ptr, rr_n, owner_n, winner;
    logic [LEN_BITS-1:0]   remaining, rem_n;
    logic [LEN_BITS-1:0]   lens [NUM_REQ];
    logic                  found;
    logic                  cred_ok;

    // The round-robin pointer wraps at NUM_REQ, not at 2^REQ_BITS.
    function automatic logic [REQ_BITS-1:0] next_idx(input logic [REQ_BITS-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
        assign lens[g] = req_len[g*LEN_BITS +: LEN_BITS];
    end

    assign cred_ok   = (credit_count != '0);
    assign valid_out = |grant;
    assign locked    = (state == BUSY);

    // Pick the first requester at or after rr_ptr, wrapping around.
    always_comb begin
        int                  idx;
        logic [REQ_BITS-1:0] idx_b;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_b  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_b = REQ_BITS'(idx);
            if (!found && req[idx_b]) begin
                found  = 1'b1;
                winner = idx_b;
            end
        end
    end

    // Grant generation and next-state for the wormhole lock.
    always_comb begin
        grant   = '0;
        state_n = state;
        rr_n    = rr_ptr;
        owner_n = owner;
        rem_n   = remaining;
        if (!reset && cred_ok) begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant[winner] = 1'b1;
                        // A zero-length packet is header only, so there is nothing to lock.
                        if (lens[winner] == '0) begin
                            rr_n = next_idx(winner);
                        end else begin
                            state_n = BUSY;
                            owner_n = winner;
                            rem_n   = lens[winner];
                        end
                    end
                end
                BUSY: begin
                    if (req[owner]) begin
                        grant[owner] = 1'b1;
                        if (remaining == LEN_BITS'(1)) begin
                            state_n = IDLE;
                            rr_n    = next_idx(owner);
                            owner_n = '0;
                            rem_n   = '0;
                        end else begin
                            rem_n = remaining - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State, pointer, owner and remaining-flit registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            remaining <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_n;
            owner     <= owner_n;
            remaining <= rem_n;
        end
    end

    // Credit counter. A flit sent and a credit returned in the same cycle cancel out.
    // A return while already full is an upstream bug, so it is latched in credit_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_count <= BUFFER_BITS'(BUFFER_SIZE);
            credit_err   <= 1'b0;
        end else if (valid_out && !yummy_in) begin
            credit_count <= credit_count - 1'b1;
        end else if (yummy_in && !valid_out) begin
            if (credit_count == BUFFER_BITS'(BUFFER_SIZE))
                credit_err <= 1'b1;
            else
                credit_count <= credit_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: directed scenarios followed by random traffic.
// Every cycle is checked against a packet-level reference model.
module tb_noc_output_arbiter;

    localparam int N  = 5;
    localparam int LB = 8;
    localparam int BS = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*LB-1:0] req_len = '0;
    logic            yummy_in = 1'b0;
    logic [N-1:0]    grant;
    logic            valid_out, locked, credit_err;
    logic [2:0]      owner, credit_count;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state, kept at the packet level.
    logic m_locked;
    int   m_owner, m_rr, m_rem, m_cred;
    logic m_err;

    noc_output_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len), .yummy_in(yummy_in),
        .grant(grant), .valid_out(valid_out), .locked(locked), .owner(owner),
        .credit_count(credit_count), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic void model_reset();
        m_locked = 1'b0; m_owner = 0; m_rr = 0; m_rem = 0; m_cred = BS; m_err = 1'b0;
    endfunction

    // Who should be sent this cycle, given the requests and the model state.
    function automatic logic [N-1:0] model_grant(input logic [N-1:0] r);
        logic [N-1:0] g;
        g = '0;
        if (m_cred == 0) return g;
        if (m_locked) begin
            if (r[m_owner]) g[m_owner] = 1'b1;
            return g;
        end
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (r[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // One clock cycle: drive the inputs, check all outputs, then advance the model.
    task automatic cycle(input logic [N-1:0] r, input logic [N*LB-1:0] lens, input logic y);
        logic [N-1:0] g;
        int w, len;
        @(negedge clk);
        req = r; req_len = lens; yummy_in = y;
        #1;
        g = model_grant(r);
        chk("grant", 32'(grant), 32'(g));
        chk("valid_out", 32'(valid_out), 32'(|g));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("credit_count", 32'(credit_count), 32'(m_cred));
        chk("credit_err", 32'(credit_err), 32'(m_err));
        @(posedge clk);
        if ((|g) && !y) m_cred--;
        else if (y && !(|g)) begin
            if (m_cred == BS) m_err = 1'b1;
            else m_cred++;
        end
        if (|g) begin
            w = 0;
            for (int i = 0; i < N; i++) if (g[i]) w = i;
            if (!m_locked) begin
                len = int'(lens[w*LB +: LB]);
                if (len == 0) m_rr = (w + 1) % N;
                else begin
                    m_locked = 1'b1; m_owner = w; m_rem = len;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_locked = 1'b0; m_rr = (m_owner + 1) % N; m_owner = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req = '1; yummy_in = 1'b0;
        #1;
        chk("grant_in_reset", 32'(grant), 32'd0);
        chk("valid_in_reset", 32'(valid_out), 32'd0);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0; req = '0;
        #1;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_credit", 32'(credit_count), 32'(BS));
        chk("rst_err", 32'(credit_err), 32'd0);
    endtask

    initial begin
        logic [N-1:0]    r;
        logic [N*LB-1:0] l;
        logic            y;
        model_reset();

        // Drain credits with zero-length packets from requester 0, then stall.
        do_reset();
        repeat (5) cycle(5'b00001, '0, 1'b0);
        #1 chk("cc_drained", 32'(credit_count), 32'd0);

        // One returned credit allows one more grant. A send and a return in the same cycle cancel.
        cycle(5'b00000, '0, 1'b1);
        cycle(5'b00001, '0, 1'b0);
        cycle(5'b00000, '0, 1'b1);
        cycle(5'b00001, '0, 1'b1);
        #1 chk("cc_hold_both", 32'(credit_count), 32'd1);

        // With all requesters active, the grant rotates around all five and wraps.
        do_reset();
        repeat (6) cycle(5'b11111, '0, 1'b1);

        // Requester 2 sends a 3-flit payload while requester 0 waits.
        do_reset();
        l = {8'd0, 8'd0, 8'd3, 8'd0, 8'd0};
        repeat (5) cycle(5'b00101, l, 1'b1);
        cycle(5'b11111, '0, 1'b1);

        // Owner 1 goes quiet mid-packet and the lock is held through the bubbles.
        do_reset();
        l = {8'd0, 8'd0, 8'd0, 8'd4, 8'd0};
        repeat (3) cycle(5'b00010, l, 1'b1);
        repeat (3) cycle(5'b11101, l, 1'b0);
        #1 chk("bubble_locked", 32'(locked), 32'd1);
        chk("bubble_owner", 32'(owner), 32'd1);
        repeat (2) cycle(5'b00010, l, 1'b1);
        cycle(5'b00000, l, 1'b0);
        #1 chk("unlocked", 32'(locked), 32'd0);

        // A credit return while full sets the error flag. The flag is sticky until a reset mid-packet.
        do_reset();
        cycle(5'b00000, '0, 1'b1);
        cycle(5'b00000, '0, 1'b0);
        #1 chk("err_sticky", 32'(credit_err), 32'd1);
        chk("cc_full", 32'(credit_count), 32'(BS));
        l = {8'd0, 8'd0, 8'd0, 8'd0, 8'd5};
        repeat (2) cycle(5'b00001, l, 1'b0);
        do_reset();

        // Random traffic with short packets and sporadic credit returns.
        for (int it = 0; it < 400; it++) begin
            if (it % 130 == 129) do_reset();
            r = N'($urandom_range(0, 31));
            for (int i = 0; i < N; i++) l[i*LB +: LB] = LB'($urandom_range(0, 3));
            y = ($urandom_range(0, 9) < 4);
            cycle(r, l, y);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
